// File: rtl/fetch_decode_pipe_reg.sv
// Y86-64 F and D pipeline registers with the hazard control unit.
// Stall/bubble for load-use, ret and mispredicted jXX hazards.
module fetch_decode_pipe_reg #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  f_stat,
  input  logic [3:0]  f_icode,
  input  logic [3:0]  f_ifun,
  input  logic [3:0]  f_rA,
  input  logic [3:0]  f_rB,
  input  logic [63:0] f_valC,
  input  logic [63:0] f_valP,
  input  logic [63:0] f_predPC,
  input  logic [3:0]  d_srcA,
  input  logic [3:0]  d_srcB,
  input  logic [3:0]  E_icode,
  input  logic [3:0]  E_dstM,
  input  logic        e_Cnd,
  input  logic [3:0]  M_icode,
  output logic [63:0] F_predPC,
  output logic [1:0]  D_stat,
  output logic [3:0]  D_icode,
  output logic [3:0]  D_ifun,
  output logic [3:0]  D_rA,
  output logic [3:0]  D_rB,
  output logic [63:0] D_valC,
  output logic [63:0] D_valP,
  output logic        F_stall,
  output logic        D_stall,
  output logic        D_bubble,
  output logic        E_bubble
);

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;

  logic        load_use;
  logic        ret_pend;
  logic        mispred;

  logic [63:0] pc_q, pc_d;
  logic [1:0]  stat_q, stat_d;
  logic [3:0]  icode_q, icode_d;
  logic [3:0]  ifun_q, ifun_d;
  logic [3:0]  ra_q, ra_d;
  logic [3:0]  rb_q, rb_d;
  logic [63:0] valc_q, valc_d;
  logic [63:0] valp_q, valp_d;

  always_comb begin
    load_use = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ))
            && ((E_dstM == d_srcA) || (E_dstM == d_srcB))
            && (E_dstM != R_NONE);
    ret_pend = (icode_q == I_RET) || (E_icode == I_RET)
            || (M_icode == I_RET);
    mispred  = (E_icode == I_JXX) && !e_Cnd;
    F_stall  = load_use | ret_pend;
    D_stall  = load_use;
    D_bubble = mispred | (!load_use & ret_pend);
    E_bubble = mispred | load_use;
  end

  // Stall outranks bubble so a held D never loses its instruction.
  always_comb begin
    pc_d    = F_stall ? pc_q : f_predPC;
    stat_d  = stat_q;
    icode_d = icode_q;
    ifun_d  = ifun_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    valc_d  = valc_q;
    valp_d  = valp_q;
    if (D_stall) begin
      icode_d = icode_q;
    end else if (D_bubble) begin
      stat_d  = 2'b00;
      icode_d = I_NOP;
      ifun_d  = 4'h0;
      ra_d    = R_NONE;
      rb_d    = R_NONE;
      valc_d  = 64'h0;
      valp_d  = 64'h0;
    end else begin
      stat_d  = f_stat;
      icode_d = f_icode;
      ifun_d  = f_ifun;
      ra_d    = f_rA;
      rb_d    = f_rB;
      valc_d  = f_valC;
      valp_d  = f_valP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      stat_q  <= 2'b00;
      icode_q <= I_NOP;
      ifun_q  <= 4'h0;
      ra_q    <= R_NONE;
      rb_q    <= R_NONE;
      valc_q  <= 64'h0;
      valp_q  <= 64'h0;
    end else begin
      pc_q    <= pc_d;
      stat_q  <= stat_d;
      icode_q <= icode_d;
      ifun_q  <= ifun_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      valc_q  <= valc_d;
      valp_q  <= valp_d;
    end
  end

  assign F_predPC = pc_q;
  assign D_stat   = stat_q;
  assign D_icode  = icode_q;
  assign D_ifun   = ifun_q;
  assign D_rA     = ra_q;
  assign D_rB     = rb_q;
  assign D_valC   = valc_q;
  assign D_valP   = valp_q;

endmodule

// File: tb/tb_fetch_decode_pipe_reg.sv
// Directed bench for fetch_decode_pipe_reg: scoreboarded register
// state per edge plus immediate checks of the hazard controls.
module tb_fetch_decode_pipe_reg;

  localparam logic [63:0] RPC = 64'h100;

  typedef struct packed {
    logic [63:0] pc;
    logic [1:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
  } st_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  f_stat;
  logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
  logic [63:0] f_valC, f_valP, f_predPC;
  logic [3:0]  d_srcA, d_srcB, E_icode, E_dstM, M_icode;
  logic        e_Cnd;
  logic [63:0] F_predPC;
  logic [1:0]  D_stat;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP;
  logic        F_stall, D_stall, D_bubble, E_bubble;

  int checks = 0;
  int failures = 0;
  st_t sb[$];

  always #5 clk = ~clk;

  fetch_decode_pipe_reg #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .f_stat(f_stat), .f_icode(f_icode), .f_ifun(f_ifun),
    .f_rA(f_rA), .f_rB(f_rB), .f_valC(f_valC),
    .f_valP(f_valP), .f_predPC(f_predPC),
    .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
    .M_icode(M_icode),
    .F_predPC(F_predPC), .D_stat(D_stat),
    .D_icode(D_icode), .D_ifun(D_ifun),
    .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP),
    .F_stall(F_stall), .D_stall(D_stall),
    .D_bubble(D_bubble), .E_bubble(E_bubble)
  );

  function automatic st_t bub(input logic [63:0] pc);
    bub = '{pc, 2'b00, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0};
  endfunction

  function automatic st_t cur_f();
    cur_f = '{f_predPC, f_stat, f_icode, f_ifun, f_rA, f_rB,
              f_valC, f_valP};
  endfunction

  task automatic set_f(input logic [1:0] s, input logic [3:0] ic,
                       input logic [3:0] fn, input logic [3:0] a,
                       input logic [3:0] b, input logic [63:0] c,
                       input logic [63:0] p, input logic [63:0] pp);
    f_stat = s; f_icode = ic; f_ifun = fn; f_rA = a; f_rB = b;
    f_valC = c; f_valP = p; f_predPC = pp;
  endtask

  task automatic ctl(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    #1;
    obs = {F_stall, D_stall, D_bubble, E_bubble};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s ctl obs=%b exp=%b", tag, obs, exp);
    end
  endtask

  task automatic edge_chk(input string tag);
    st_t obs, exp;
    @(posedge clk);
    #1;
    obs = '{F_predPC, D_stat, D_icode, D_ifun, D_rA, D_rB,
            D_valC, D_valP};
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL %s scoreboard empty obs=%h exp=none", tag, obs);
    end else begin
      exp = sb.pop_front();
      assert (obs === exp) else begin
        failures++;
        $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
    end
  endtask

  initial begin
    st_t held;
    rst = 1'b1;
    set_f(2'b00, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 64'h0);
    d_srcA = 4'hF; d_srcB = 4'hF;
    E_icode = 4'h1; E_dstM = 4'hF; M_icode = 4'h1; e_Cnd = 1'b1;
    @(negedge clk);

    // T1 reset
    sb.push_back(bub(RPC));
    edge_chk("t1_reset");
    rst = 1'b0;
    ctl("t1_ctl", 4'b0000);

    // T2 normal flow, two patterns incl. non-AOK status
    set_f(2'b00, 4'h3, 4'h0, 4'hF, 4'h2, 64'h55, 64'h0A, 64'h0A);
    sb.push_back(cur_f());
    ctl("t2_ctl", 4'b0000);
    edge_chk("t2_flow");
    set_f(2'b01, 4'h6, 4'h1, 4'h1, 4'h2, 64'h0, 64'h0C, 64'h0C);
    sb.push_back(cur_f());
    edge_chk("t2_hlt_flow");
    held = '{64'h0C, 2'b01, 4'h6, 4'h1, 4'h1, 4'h2, 64'h0, 64'h0C};

    // no-register E_dstM must not trigger load-use
    E_icode = 4'h5; E_dstM = 4'hF; d_srcA = 4'hF;
    ctl("dstm_none", 4'b0000);

    // T3 load-use via mrmovq, then popq on srcB
    E_dstM = 4'h3; d_srcA = 4'h3;
    set_f(2'b00, 4'h2, 4'h0, 4'h4, 4'h5, 64'h0, 64'h20, 64'h20);
    ctl("t3_ctl", 4'b1101);
    sb.push_back(held);
    edge_chk("t3_hold");
    E_icode = 4'hB; d_srcA = 4'hF; d_srcB = 4'h3;
    ctl("t3_popq_ctl", 4'b1101);

    // T6 reset during stall
    rst = 1'b1;
    sb.push_back(bub(RPC));
    edge_chk("t6_rst_stall");
    rst = 1'b0;
    E_icode = 4'h1; E_dstM = 4'hF; d_srcB = 4'hF;
    ctl("t6_ctl", 4'b0000);

    // T4 mispredict
    set_f(2'b00, 4'h7, 4'h1, 4'hF, 4'hF, 64'h80, 64'h49, 64'h80);
    sb.push_back(cur_f());
    edge_chk("t4_load_jxx");
    E_icode = 4'h7; e_Cnd = 1'b1;
    ctl("t4_taken_ok", 4'b0000);
    e_Cnd = 1'b0;
    set_f(2'b00, 4'h2, 4'h0, 4'h1, 4'h2, 64'h0, 64'h50, 64'h50);
    ctl("t4_ctl", 4'b0011);
    sb.push_back(bub(64'h50));
    edge_chk("t4_bubble");

    // mispredict with ret pending: bubble D, stall F
    M_icode = 4'h9;
    ctl("mis_ret_ctl", 4'b1011);
    sb.push_back(bub(64'h50));
    edge_chk("mis_ret");
    E_icode = 4'h1; M_icode = 4'h1; e_Cnd = 1'b1;

    // T5 ret through D, E, M
    set_f(2'b00, 4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h61, 64'h61);
    sb.push_back(cur_f());
    edge_chk("t5_load_ret");
    held = cur_f();
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
    ctl("t5_ret_lu_ctl", 4'b1101);
    E_icode = 4'h1; E_dstM = 4'hF; d_srcA = 4'hF;
    set_f(2'b00, 4'h2, 4'h0, 4'h1, 4'h2, 64'h0, 64'h70, 64'h70);
    ctl("t5_d_ctl", 4'b1010);
    sb.push_back(bub(64'h61));
    edge_chk("t5_d");
    E_icode = 4'h9;
    ctl("t5_e_ctl", 4'b1010);
    sb.push_back(bub(64'h61));
    edge_chk("t5_e");
    E_icode = 4'h1; M_icode = 4'h9;
    ctl("t5_m_ctl", 4'b1010);
    sb.push_back(bub(64'h61));
    edge_chk("t5_m");
    M_icode = 4'h1;
    ctl("t5_resume_ctl", 4'b0000);
    sb.push_back(cur_f());
    edge_chk("t5_resume");

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL sb_drain obs=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
